// File: rtl/edge_capture_if.sv
// Host-side bundle of the edge-capture block: the sampled input, the clear
// strobe and every measurement result.
interface edge_capture_if #(
  parameter int CNT_WIDTH = 16,
  parameter int PW_WIDTH  = 32
);
  logic                 din;
  logic                 clear;
  logic                 rise_flag;
  logic                 fall_flag;
  logic [CNT_WIDTH-1:0] rise_count;
  logic [CNT_WIDTH-1:0] fall_count;
  logic [PW_WIDTH-1:0]  high_time;
  logic                 overflow;
  logic                 level;

  modport master (
    output din, clear,
    input  rise_flag, fall_flag, rise_count, fall_count, high_time, overflow, level
  );

  modport slave (
    input  din, clear,
    output rise_flag, fall_flag, rise_count, fall_count, high_time, overflow, level
  );
endinterface

// File: rtl/edge_capture_sat_counter.sv
// Saturating up-counter used for pulse-width measurement: load-to-1, increment,
// and a one-shot indication on the cycle the all-ones value is first reached.
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] cnt_o,
  output logic             hit_o
);
  localparam logic [WIDTH-1:0] SAT_MAX = '1;

  logic [WIDTH-1:0] cnt_q, cnt_d;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = WIDTH'(1);
    end else if (inc_i && (cnt_q != SAT_MAX)) begin
      cnt_d = cnt_q + WIDTH'(1);
    end
  end

  // NOTE: reset is synchronous; rst_n is only looked at inside the clocked process.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;
  // Fires only on the transition into saturation, not while it stays there.
  assign hit_o = (cnt_d == SAT_MAX) && (cnt_q != SAT_MAX);
endmodule

// File: rtl/edge_capture.sv
// Edge detector with sticky flags, free-running edge counters and a
// high-pulse width measurement driven by a two-state FSM.
module edge_capture #(
  parameter int CNT_WIDTH = 16,
  parameter int PW_WIDTH  = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  edge_capture_if.slave  bus
);
  typedef enum logic {ST_LOW, ST_HIGH} state_e;

  state_e               state_q, state_d;
  logic                 din_q;
  logic                 rise, fall;
  logic                 cnt_load, cnt_inc, capture;
  logic [PW_WIDTH-1:0]  pw_cnt;
  logic                 pw_hit;

  logic                 rise_flag_q, rise_flag_d;
  logic                 fall_flag_q, fall_flag_d;
  logic                 overflow_q, overflow_d;
  logic [CNT_WIDTH-1:0] rise_count_q, rise_count_d;
  logic [CNT_WIDTH-1:0] fall_count_q, fall_count_d;
  logic [PW_WIDTH-1:0]  high_time_q, high_time_d;

  assign rise = bus.din & ~din_q;
  assign fall = ~bus.din & din_q;

  // Width FSM: state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= bus.din ? ST_HIGH : ST_LOW;
    end else begin
      state_q <= state_d;
    end
  end

  // Width FSM: next state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_LOW:  if (rise) state_d = ST_HIGH;
      ST_HIGH: if (fall) state_d = ST_LOW;
      default: state_d = ST_LOW;
    endcase
  end

  // Width FSM: counter controls and capture strobe.
  always_comb begin
    cnt_load = 1'b0;
    cnt_inc  = 1'b0;
    capture  = 1'b0;
    case (state_q)
      ST_LOW:  cnt_load = rise;
      ST_HIGH: begin
        cnt_inc = bus.din;
        capture = fall;
      end
      default: ;
    endcase
  end

  sat_counter #(.WIDTH(PW_WIDTH)) u_pw_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (cnt_load),
    .inc_i  (cnt_inc),
    .cnt_o  (pw_cnt),
    .hit_o  (pw_hit)
  );

  // Set has priority over clear for every sticky flag.
  always_comb begin
    rise_flag_d  = rise   | (rise_flag_q & ~bus.clear);
    fall_flag_d  = fall   | (fall_flag_q & ~bus.clear);
    overflow_d   = pw_hit | (overflow_q  & ~bus.clear);
    rise_count_d = rise ? rise_count_q + CNT_WIDTH'(1) : rise_count_q;
    fall_count_d = fall ? fall_count_q + CNT_WIDTH'(1) : fall_count_q;
    high_time_d  = capture ? pw_cnt : high_time_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // Track din through reset so a level already high at release is not an edge.
      din_q        <= bus.din;
      rise_flag_q  <= 1'b0;
      fall_flag_q  <= 1'b0;
      overflow_q   <= 1'b0;
      rise_count_q <= '0;
      fall_count_q <= '0;
      high_time_q  <= '0;
    end else begin
      din_q        <= bus.din;
      rise_flag_q  <= rise_flag_d;
      fall_flag_q  <= fall_flag_d;
      overflow_q   <= overflow_d;
      rise_count_q <= rise_count_d;
      fall_count_q <= fall_count_d;
      high_time_q  <= high_time_d;
    end
  end

  assign bus.level      = din_q;
  assign bus.rise_flag  = rise_flag_q;
  assign bus.fall_flag  = fall_flag_q;
  assign bus.overflow   = overflow_q;
  assign bus.rise_count = rise_count_q;
  assign bus.fall_count = fall_count_q;
  assign bus.high_time  = high_time_q;
endmodule
